// File: rtl/ex_iter_unit.sv
// rtl/ex_iter_unit.sv - execute stage with registered handshaked result and iterative mul/div
module ex_iter_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   op,
    input  logic [WIDTH-1:0]  regaData,
    input  logic [WIDTH-1:0]  regbData,
    input  logic              regcWr_i,
    input  logic [ADDR_W-1:0] regcAddr_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  regcData,
    output logic [ADDR_W-1:0] regcAddr,
    output logic              regcWr
);

    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = SH_W + 1;

    localparam logic [OP_W-1:0] CMD_ADD  = OP_W'(1);
    localparam logic [OP_W-1:0] CMD_ADDI = OP_W'(2);
    localparam logic [OP_W-1:0] CMD_SUB  = OP_W'(3);
    localparam logic [OP_W-1:0] CMD_AND  = OP_W'(4);
    localparam logic [OP_W-1:0] CMD_ANDI = OP_W'(5);
    localparam logic [OP_W-1:0] CMD_OR   = OP_W'(6);
    localparam logic [OP_W-1:0] CMD_ORI  = OP_W'(7);
    localparam logic [OP_W-1:0] CMD_XOR  = OP_W'(8);
    localparam logic [OP_W-1:0] CMD_XORI = OP_W'(9);
    localparam logic [OP_W-1:0] CMD_SLL  = OP_W'(10);
    localparam logic [OP_W-1:0] CMD_SRL  = OP_W'(11);
    localparam logic [OP_W-1:0] CMD_SRA  = OP_W'(12);
    localparam logic [OP_W-1:0] CMD_LUI  = OP_W'(13);
    localparam logic [OP_W-1:0] CMD_SLT  = OP_W'(14);
    localparam logic [OP_W-1:0] CMD_MULU = OP_W'(15);
    localparam logic [OP_W-1:0] CMD_DIVU = OP_W'(16);
    localparam logic [OP_W-1:0] CMD_REMU = OP_W'(17);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [OP_W-1:0]    op_q;
    logic [WIDTH-1:0]   a_q;     // multiplicand, or dividend shifting into quotient
    logic [WIDTH-1:0]   b_q;     // multiplier, or divisor
    logic [WIDTH-1:0]   acc_q;   // partial product, or partial remainder
    logic               pend_wr;
    logic [ADDR_W-1:0]  pend_addr;

    logic               accept;
    logic               is_iter;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_wr;

    logic [WIDTH-1:0]   mul_acc_nxt;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   div_rem_nxt;
    logic [WIDTH-1:0]   div_q_nxt;
    logic [WIDTH-1:0]   iter_res;

    // Issue is blocked while iterating or while a held result is not being drained.
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_iter  = (op == CMD_MULU) || (op == CMD_DIVU) || (op == CMD_REMU);
    assign shamt    = regbData[SH_W-1:0];

    // Single-cycle ALU result and forwarded write enable for the current input op.
    always_comb begin
        alu_res = '0;
        alu_wr  = regcWr_i;
        case (op)
            CMD_ADD, CMD_ADDI: alu_res = regaData + regbData;
            CMD_SUB:           alu_res = regaData - regbData;
            CMD_AND, CMD_ANDI: alu_res = regaData & regbData;
            CMD_OR,  CMD_ORI:  alu_res = regaData | regbData;
            CMD_XOR, CMD_XORI: alu_res = regaData ^ regbData;
            CMD_SLL:           alu_res = regaData << shamt;
            CMD_SRL:           alu_res = regaData >> shamt;
            CMD_SRA:           alu_res = WIDTH'($signed(regaData) >>> shamt);
            CMD_LUI:           alu_res = regaData << (WIDTH / 2);
            CMD_SLT:           alu_res = {{(WIDTH-1){1'b0}}, ($signed(regaData) < $signed(regbData))};
            default: begin
                alu_res = '0;
                alu_wr  = 1'b0;
            end
        endcase
    end

    // One shift-add step and one restoring-division step from the current iteration registers.
    always_comb begin
        mul_acc_nxt = acc_q + (b_q[0] ? a_q : '0);
        div_shift   = {acc_q, a_q[WIDTH-1]};
        div_ok      = (div_shift >= {1'b0, b_q});
        div_sub     = div_shift[WIDTH-1:0] - b_q;
        div_rem_nxt = div_ok ? div_sub : div_shift[WIDTH-1:0];
        div_q_nxt   = {a_q[WIDTH-2:0], div_ok};
        if (op_q == CMD_MULU) begin
            iter_res = mul_acc_nxt;
        end else if (op_q == CMD_DIVU) begin
            iter_res = div_q_nxt;
        end else begin
            iter_res = div_rem_nxt;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: iterative ops enter BUSY, the last iteration returns to IDLE, flush always idles.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && is_iter) state_nxt = BUSY;
                BUSY:    if (cnt == CNT_W'(1)) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: operand latching, iteration steps, and the registered result with its handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            pend_wr   <= 1'b0;
            pend_addr <= '0;
            out_valid <= 1'b0;
            regcData  <= '0;
            regcAddr  <= '0;
            regcWr    <= 1'b0;
        end else if (flush) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            regcWr    <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && !is_iter) begin
                regcData  <= alu_res;
                regcAddr  <= regcAddr_i;
                regcWr    <= alu_wr;
                out_valid <= 1'b1;
            end
            if (accept && is_iter) begin
                op_q      <= op;
                a_q       <= regaData;
                b_q       <= regbData;
                acc_q     <= '0;
                pend_wr   <= regcWr_i;
                pend_addr <= regcAddr_i;
                cnt       <= CNT_W'(WIDTH);
            end
            if (state == BUSY) begin
                cnt <= cnt - CNT_W'(1);
                if (op_q == CMD_MULU) begin
                    acc_q <= mul_acc_nxt;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                end else begin
                    acc_q <= div_rem_nxt;
                    a_q   <= div_q_nxt;
                end
                if (cnt == CNT_W'(1)) begin
                    regcData  <= iter_res;
                    regcAddr  <= pend_addr;
                    regcWr    <= pend_wr;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_iter_unit.sv
// tb/tb_ex_iter_unit.sv - directed self-checking bench for ex_iter_unit
module tb_ex_iter_unit;

    localparam logic [5:0] ADD  = 6'd1;
    localparam logic [5:0] SUB  = 6'd3;
    localparam logic [5:0] XORI = 6'd9;
    localparam logic [5:0] SLL  = 6'd10;
    localparam logic [5:0] SRL  = 6'd11;
    localparam logic [5:0] SRA  = 6'd12;
    localparam logic [5:0] LUI  = 6'd13;
    localparam logic [5:0] SLT  = 6'd14;
    localparam logic [5:0] MULU = 6'd15;
    localparam logic [5:0] DIVU = 6'd16;
    localparam logic [5:0] REMU = 6'd17;
    localparam logic [5:0] BAD  = 6'd63;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  op;
    logic [31:0] regaData;
    logic [31:0] regbData;
    logic        regcWr_i;
    logic [4:0]  regcAddr_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] regcData;
    logic [4:0]  regcAddr;
    logic        regcWr;

    int pass_cnt  = 0;
    int total_cnt = 0;

    ex_iter_unit #(.WIDTH(32), .ADDR_W(5), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .regaData(regaData), .regbData(regbData),
        .regcWr_i(regcWr_i), .regcAddr_i(regcAddr_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .regcData(regcData), .regcAddr(regcAddr), .regcWr(regcWr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic wr, input logic [4:0] ad);
        op         = o;
        regaData   = a;
        regbData   = b;
        regcWr_i   = wr;
        regcAddr_i = ad;
        in_valid   = 1'b1;
    endtask

    task automatic test_reset;
        logic rose;
        #1;
        total_cnt++;
        if ({out_valid, regcWr, regcAddr, regcData} !== 39'd0)
            $display("FAIL reset_outputs: got v=%b wr=%b a=%h d=%h want all 0", out_valid, regcWr, regcAddr, regcData);
        else pass_cnt++;
        tick; tick;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        else pass_cnt++;
        out_ready = 1'b1;
        drive(ADD, 32'd3, 32'd4, 1'b1, 5'd7);
        tick;
        drive(MULU, 32'h0001_0000, 32'h0001_0001, 1'b1, 5'd12);
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0 || regcData !== 32'd7)
            $display("FAIL reset_pre_busy: got rdy=%b d=%h want rdy=0 d=00000007", in_ready, regcData);
        else pass_cnt++;
        repeat (5) tick;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, regcWr, regcAddr, regcData} !== 39'd0)
            $display("FAIL reset_mid_mulu: got v=%b wr=%b a=%h d=%h want all 0", out_valid, regcWr, regcAddr, regcData);
        else pass_cnt++;
        tick; tick;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_mid_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        else pass_cnt++;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) rose = 1'b1;
            tick;
        end
        total_cnt++;
        if (rose !== 1'b0)
            $display("FAIL reset_abort: got out_valid rose=%b want 0", rose);
        else pass_cnt++;
    endtask

    task automatic test_alu_stream;
        logic [5:0]  t_op  [8];
        logic [31:0] t_a   [8];
        logic [31:0] t_b   [8];
        logic [31:0] t_exp [8];
        logic        t_wr  [8];
        t_op[0] = ADD;  t_a[0] = 32'h7FFF_FFFF; t_b[0] = 32'd1;  t_exp[0] = 32'h8000_0000; t_wr[0] = 1'b1;
        t_op[1] = SRA;  t_a[1] = 32'h8000_0000; t_b[1] = 32'd4;  t_exp[1] = 32'hF800_0000; t_wr[1] = 1'b0;
        t_op[2] = SLT;  t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'd1;  t_exp[2] = 32'h0000_0001; t_wr[2] = 1'b1;
        t_op[3] = LUI;  t_a[3] = 32'h0000_1234; t_b[3] = 32'd0;  t_exp[3] = 32'h1234_0000; t_wr[3] = 1'b1;
        t_op[4] = SUB;  t_a[4] = 32'd5;         t_b[4] = 32'd7;  t_exp[4] = 32'hFFFF_FFFE; t_wr[4] = 1'b1;
        t_op[5] = SLL;  t_a[5] = 32'd3;         t_b[5] = 32'd36; t_exp[5] = 32'h0000_0030; t_wr[5] = 1'b0;
        t_op[6] = XORI; t_a[6] = 32'h0000_F0F0; t_b[6] = 32'hFF; t_exp[6] = 32'h0000_F00F; t_wr[6] = 1'b1;
        t_op[7] = SRL;  t_a[7] = 32'h8000_0000; t_b[7] = 32'd31; t_exp[7] = 32'h0000_0001; t_wr[7] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(t_op[i], t_a[i], t_b[i], t_wr[i], 5'(i + 1));
            total_cnt++;
            if (in_ready !== 1'b1)
                $display("FAIL alu_ready[%0d]: got %b want 1", i, in_ready);
            else pass_cnt++;
            tick;
            total_cnt++;
            if (out_valid !== 1'b1 || regcData !== t_exp[i] || regcAddr !== 5'(i + 1) || regcWr !== t_wr[i])
                $display("FAIL alu_result[%0d]: got v=%b d=%h a=%0d wr=%b want v=1 d=%h a=%0d wr=%b",
                         i, out_valid, regcData, regcAddr, regcWr, t_exp[i], i + 1, t_wr[i]);
            else pass_cnt++;
        end
        in_valid = 1'b0;
        tick;
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL alu_drain: got v=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_iter(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp, input logic [4:0] ad);
        int   lat;
        logic bad_rdy;
        out_ready = 1'b1;
        drive(o, a, b, 1'b1, ad);
        tick;
        in_valid = 1'b0;
        lat     = 0;
        bad_rdy = 1'b0;
        while (!out_valid && lat < 40) begin
            if (in_ready !== 1'b0) bad_rdy = 1'b1;
            tick;
            lat++;
        end
        total_cnt++;
        if (lat != 32)
            $display("FAIL iter_latency op%0d: got %0d want 32", o, lat);
        else pass_cnt++;
        total_cnt++;
        if (bad_rdy !== 1'b0)
            $display("FAIL iter_in_ready op%0d: got in_ready high during busy, want 0", o);
        else pass_cnt++;
        total_cnt++;
        if (regcData !== exp || regcAddr !== ad || regcWr !== 1'b1)
            $display("FAIL iter_result op%0d: got d=%h a=%0d wr=%b want d=%h a=%0d wr=1", o, regcData, regcAddr, regcWr, exp, ad);
        else pass_cnt++;
        tick;
    endtask

    task automatic test_backpressure;
        logic held_ok;
        out_ready = 1'b0;
        drive(ADD, 32'd10, 32'd20, 1'b1, 5'd5);
        tick;
        drive(SUB, 32'd50, 32'd8, 1'b0, 5'd6);
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b1 || regcData !== 32'd30 || regcAddr !== 5'd5 || in_ready !== 1'b0)
                held_ok = 1'b0;
            tick;
        end
        total_cnt++;
        if (held_ok !== 1'b1)
            $display("FAIL bp_hold: got v=%b d=%h rdy=%b want v=1 d=0000001e rdy=0", out_valid, regcData, in_ready);
        else pass_cnt++;
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1)
            $display("FAIL bp_ready_raise: got %b want 1", in_ready);
        else pass_cnt++;
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || regcData !== 32'd42 || regcAddr !== 5'd6 || regcWr !== 1'b0)
            $display("FAIL bp_sub: got v=%b d=%h a=%0d wr=%b want v=1 d=0000002a a=6 wr=0", out_valid, regcData, regcAddr, regcWr);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (out_valid !== 1'b0)
            $display("FAIL bp_drain: got v=%b want 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        logic rose;
        out_ready = 1'b1;
        drive(DIVU, 32'd1000, 32'd3, 1'b1, 5'd8);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) rose = 1'b1;
            tick;
        end
        total_cnt++;
        if (rose !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_divu: got rose=%b rdy=%b want rose=0 rdy=1", rose, in_ready);
        else pass_cnt++;
        drive(ADD, 32'd2, 32'd3, 1'b1, 5'd10);
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || regcData !== 32'd5 || regcAddr !== 5'd10)
            $display("FAIL flush_next_add: got v=%b d=%h a=%0d want v=1 d=00000005 a=10", out_valid, regcData, regcAddr);
        else pass_cnt++;
        tick;
        drive(ADD, 32'd9, 32'd9, 1'b1, 5'd11);
        flush = 1'b1;
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || regcWr !== 1'b0)
            $display("FAIL flush_accept: got v=%b wr=%b want v=0 wr=0", out_valid, regcWr);
        else pass_cnt++;
        tick;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_accept_after: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_unknown;
        out_ready = 1'b1;
        drive(BAD, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5'd9);
        tick;
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || regcWr !== 1'b0 || regcData !== 32'd0 || regcAddr !== 5'd9)
            $display("FAIL unknown_op: got v=%b wr=%b d=%h a=%0d want v=1 wr=0 d=00000000 a=9", out_valid, regcWr, regcData, regcAddr);
        else pass_cnt++;
        tick;
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        op         = '0;
        regaData   = '0;
        regbData   = '0;
        regcWr_i   = 1'b0;
        regcAddr_i = '0;
        test_reset;
        test_alu_stream;
        test_iter(MULU, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 5'd13);
        test_iter(DIVU, 32'd100, 32'd7, 32'd14, 5'd14);
        test_iter(REMU, 32'd100, 32'd7, 32'd2, 5'd15);
        test_iter(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 5'd16);
        test_iter(REMU, 32'd5, 32'd0, 32'd5, 5'd17);
        test_backpressure;
        test_flush;
        test_unknown;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
